pulse_width_detector: RTL and testbench

PULSE_WIDTH_DETECTOR -- requirements
Module: pulse_width_detector

---
 rtl/pulse_width_detector.sv | 193 +++++++++++++++++++
 tb/tb_pulse_width_detector.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_detector.sv
// -----------------------------------------------------------------------------
// pulse_width_detector
//
// Measures the length of pulses on N independent channels. A pulse is a run of
// consecutive clock edges at which the channel sits at its active level (high
// when pol=0, low when pol=1). Each channel reports, as one-cycle registered
// strobes, the start and end of a pulse, an over-length warning the moment a
// pulse exceeds max_len, and acceptance when a pulse ends inside
// [max(min_len,1), max_len]. The length of the last ended pulse is held on len.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-low reset
//   a         [N]        monitored signals, one per channel
//   pol       1          0 = measure high pulses, 1 = measure low pulses
//   min_len   [CNT_W]    minimum accepted length (0 behaves as 1)
//   max_len   [CNT_W]    maximum accepted length (all-ones = unbounded)
//   rise      [N]        strobe: pulse start seen
//   fall      [N]        strobe: pulse end seen
//   detected  [N]        strobe: ended pulse was within limits
//   too_long  [N]        strobe: active pulse just exceeded max_len
//   len       [N*CNT_W]  channel i at [i*CNT_W +: CNT_W], saturating length
// -----------------------------------------------------------------------------
module pulse_width_detector #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       a,
    input  logic               pol,
    input  logic [CNT_W-1:0]   min_len,
    input  logic [CNT_W-1:0]   max_len,
    output logic [N-1:0]       rise,
    output logic [N-1:0]       fall,
    output logic [N-1:0]       detected,
    output logic [N-1:0]       too_long,
    output logic [N*CNT_W-1:0] len
);

    localparam logic [CNT_W-1:0] SAT     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        OVER   = 2'd2
    } state_t;

    logic [CNT_W-1:0] min_eff_s;

    // Effective minimum length: a zero minimum is treated as one cycle.
    always_comb begin
        if (min_len == {CNT_W{1'b0}}) begin
            min_eff_s = CNT_ONE;
        end else begin
            min_eff_s = min_len;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic             s_s;
            logic             s_r;
            logic             start_s;
            logic             end_s;
            logic             cont_s;
            logic [CNT_W-1:0] cnt_r;
            logic [CNT_W-1:0] cnt_inc_s;
            logic [CNT_W-1:0] cnt_nxt_s;
            logic [CNT_W-1:0] len_r;
            logic [CNT_W-1:0] len_nxt_s;
            state_t           state_r;
            state_t           state_nxt_s;
            logic             rise_r;
            logic             fall_r;
            logic             det_r;
            logic             tl_r;
            logic             rise_nxt_s;
            logic             fall_nxt_s;
            logic             det_nxt_s;
            logic             tl_nxt_s;

            assign s_s     = a[i] ^ pol;
            assign start_s = s_s & ~s_r;
            assign end_s   = ~s_s & s_r;
            assign cont_s  = s_s & s_r;

            // Length counter next value: restarts at 1, saturates at SAT, clears between pulses.
            always_comb begin
                if (cnt_r == SAT) begin
                    cnt_inc_s = SAT;
                end else begin
                    cnt_inc_s = cnt_r + CNT_ONE;
                end
                if (start_s) begin
                    cnt_nxt_s = CNT_ONE;
                end else if (cont_s) begin
                    cnt_nxt_s = cnt_inc_s;
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end

            // Channel FSM state register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_r <= IDLE;
                end else begin
                    state_r <= state_nxt_s;
                end
            end

            // Channel FSM next-state logic; OVER is entered once per pulse when the
            // running length passes max_len (never with max_len = SAT, as cnt saturates).
            always_comb begin
                state_nxt_s = state_r;
                case (state_r)
                    IDLE: begin
                        if (start_s) begin
                            state_nxt_s = ACTIVE;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                    ACTIVE: begin
                        if (end_s) begin
                            state_nxt_s = IDLE;
                        end else if (cont_s && (cnt_inc_s > max_len)) begin
                            state_nxt_s = OVER;
                        end else begin
                            state_nxt_s = ACTIVE;
                        end
                    end
                    OVER: begin
                        if (end_s) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = OVER;
                        end
                    end
                    default: begin
                        state_nxt_s = IDLE;
                    end
                endcase
            end

            // Output decode; acceptance also requires cnt <= max_len so that a
            // degenerate max_len of 0 can never accept a pulse.
            always_comb begin
                rise_nxt_s = start_s;
                fall_nxt_s = end_s;
                tl_nxt_s   = (state_r == ACTIVE) && (state_nxt_s == OVER);
                det_nxt_s  = (state_r == ACTIVE) && end_s &&
                             (cnt_r >= min_eff_s) && (cnt_r <= max_len);
                if (end_s) begin
                    len_nxt_s = cnt_r;
                end else begin
                    len_nxt_s = len_r;
                end
            end

            // Datapath and output registers; reset aborts any pulse in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s_r    <= 1'b0;
                    cnt_r  <= {CNT_W{1'b0}};
                    len_r  <= {CNT_W{1'b0}};
                    rise_r <= 1'b0;
                    fall_r <= 1'b0;
                    det_r  <= 1'b0;
                    tl_r   <= 1'b0;
                end else begin
                    s_r    <= s_s;
                    cnt_r  <= cnt_nxt_s;
                    len_r  <= len_nxt_s;
                    rise_r <= rise_nxt_s;
                    fall_r <= fall_nxt_s;
                    det_r  <= det_nxt_s;
                    tl_r   <= tl_nxt_s;
                end
            end

            assign rise[i]                  = rise_r;
            assign fall[i]                  = fall_r;
            assign detected[i]              = det_r;
            assign too_long[i]              = tl_r;
            assign len[i*CNT_W +: CNT_W]    = len_r;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_width_detector.sv
// Self-checking bench for pulse_width_detector (N=4, CNT_W=4 so saturation is reachable).
module tb_pulse_width_detector;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic         clk;
    logic         rst;
    logic [3:0]   a;
    logic         pol;
    logic [3:0]   min_len;
    logic [3:0]   max_len;
    logic [3:0]   rise;
    logic [3:0]   fall;
    logic [3:0]   detected;
    logic [3:0]   too_long;
    logic [15:0]  len;

    int checks;
    int errors;

    pulse_width_detector #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .pol      (pol),
        .min_len  (min_len),
        .max_len  (max_len),
        .rise     (rise),
        .fall     (fall),
        .detected (detected),
        .too_long (too_long),
        .len      (len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (run-length based) ----------------
    int         run  [N];
    bit         sp   [N];
    bit         over [N];
    logic [3:0] m_rise, m_fall, m_det, m_tl;
    logic [15:0] m_len;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            run[i] = 0; sp[i] = 1'b0; over[i] = 1'b0;
        end
        m_rise = 4'd0; m_fall = 4'd0; m_det = 4'd0; m_tl = 4'd0; m_len = 16'd0;
    endtask

    task automatic model_edge();
        int  l;
        int  mn;
        bit  s;
        if (!rst) begin
            model_reset();
        end else begin
            m_rise = 4'd0; m_fall = 4'd0; m_det = 4'd0; m_tl = 4'd0;
            mn = (min_len == 4'd0) ? 1 : int'(min_len);
            for (int i = 0; i < N; i++) begin
                s = a[i] ^ pol;
                if (s && !sp[i]) begin
                    m_rise[i] = 1'b1;
                    run[i] = 1;
                    over[i] = 1'b0;
                end else if (s && sp[i]) begin
                    run[i] = run[i] + 1;
                    l = (run[i] > SAT) ? SAT : run[i];
                    if (!over[i] && l > int'(max_len)) begin
                        m_tl[i] = 1'b1;
                        over[i] = 1'b1;
                    end
                end else if (!s && sp[i]) begin
                    l = (run[i] > SAT) ? SAT : run[i];
                    m_fall[i] = 1'b1;
                    m_len[i*4 +: 4] = 4'(l);
                    m_det[i] = !over[i] && (l >= mn) && (l <= int'(max_len));
                end
                sp[i] = s;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance model, then compare DUT against it just after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("rise", {28'd0, rise}, {28'd0, m_rise});
        chk("fall", {28'd0, fall}, {28'd0, m_fall});
        chk("detected", {28'd0, detected}, {28'd0, m_det});
        chk("too_long", {28'd0, too_long}, {28'd0, m_tl});
        chk("len", {16'd0, len}, {16'd0, m_len});
    endtask

    // Asynchronous reset between edges (called at posedge+1); outputs must clear at once.
    task automatic do_reset(input logic pol_v);
        #2 rst = 1'b0;
        #1 chk("reset_outputs", {4'd0, rise, fall, detected, too_long, len}, 32'd0);
        model_reset();
        pol = pol_v;
        #3 rst = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  det;
        logic [3:0]  tl;
        logic [15:0] len;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [3:0] acc;
        int         tl_cnt;
        checks = 0;
        errors = 0;
        model_reset();

        // pol=0, min=2, max=4: ch0 3-edge pulse, ch1 1-edge pulse, ch2 7-edge pulse
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
        vecs[1]  = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
        vecs[2]  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 16'h0010};
        vecs[3]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0010};
        vecs[4]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 16'h0013};
        vecs[5]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 16'h0013};
        vecs[6]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0013};
        vecs[7]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0013};
        vecs[8]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0013};
        vecs[9]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 16'h0013};
        vecs[10] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0013};
        vecs[11] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0013};
        vecs[12] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 16'h0713};

        rst = 1'b0; pol = 1'b0; a = 4'd0; min_len = 4'd2; max_len = 4'd4;
        #12;
        chk("reset_state", {4'd0, rise, fall, detected, too_long, len}, 32'd0);
        rst = 1'b1;

        for (int k = 0; k < 13; k++) begin
            a = vecs[k].a;
            tick();
            chk("tbl_rise", {28'd0, rise}, {28'd0, vecs[k].rise});
            chk("tbl_fall", {28'd0, fall}, {28'd0, vecs[k].fall});
            chk("tbl_det",  {28'd0, detected}, {28'd0, vecs[k].det});
            chk("tbl_tl",   {28'd0, too_long}, {28'd0, vecs[k].tl});
            chk("tbl_len",  {16'd0, len}, {16'd0, vecs[k].len});
        end

        // Saturation: 20-edge pulse with max=SAT is never too long and is accepted at 15.
        min_len = 4'd2; max_len = 4'd15; a = 4'b1000; tl_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (too_long[3]) tl_cnt++;
        end
        a = 4'b0000;
        tick();
        chk("sat_too_long_count", 32'(tl_cnt), 32'd0);
        chk("sat_detected", {31'd0, detected[3]}, 32'd1);
        chk("sat_len", {28'd0, len[15:12]}, 32'd15);

        // Low-pulse polarity: ch0 low for 2 edges, other channels idle high.
        a = 4'b1111; min_len = 4'd1; max_len = 4'd2;
        do_reset(1'b1);
        acc = 4'd0;
        a = 4'b1110; tick(); acc |= rise | fall | detected | too_long;
        chk("pol_rise", {28'd0, rise}, 32'd1);
        tick(); acc |= rise | fall | detected | too_long;
        a = 4'b1111; tick(); acc |= rise | fall | detected | too_long;
        chk("pol_detected", {28'd0, detected}, 32'd1);
        chk("pol_fall", {28'd0, fall}, 32'd1);
        chk("pol_len", {16'd0, len}, 32'h0002);
        chk("pol_other_quiet", {28'd0, acc[3:1], 1'b0}, 32'd0);

        // Reset mid-pulse: 5-edge pulse aborted after its 3rd edge.
        a = 4'b0000; min_len = 4'd2; max_len = 4'd4;
        do_reset(1'b0);
        a = 4'b0001;
        tick(); tick(); tick();
        do_reset(1'b0);
        a = 4'b0000;
        acc = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acc |= fall | detected;
        end
        chk("abort_no_fall_det", {28'd0, acc}, 32'd0);
        chk("abort_len", {16'd0, len}, 32'd0);

        // Release with channel already active: first edge is a start edge.
        a = 4'b0001;
        do_reset(1'b0);
        tick();
        chk("release_rise", {28'd0, rise}, 32'd1);
        a = 4'b0000;
        tick();
        chk("len1_fall", {28'd0, fall}, 32'd1);
        chk("len1_no_det", {28'd0, detected}, 32'd0);

        // min_len > max_len: never accepted, other outputs still work.
        min_len = 4'd5; max_len = 4'd3; a = 4'b0001;
        tick(); tick();
        a = 4'b0000;
        tick();
        chk("minmax_fall", {28'd0, fall}, 32'd1);
        chk("minmax_no_det", {28'd0, detected}, 32'd0);
        chk("minmax_len", {28'd0, len[3:0]}, 32'd2);

        // Randomised run against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) a[i] = ~a[i];
            end
            if ($urandom_range(40) == 0) begin
                case ($urandom_range(3))
                    0: max_len = 4'd15;
                    1: max_len = 4'($urandom_range(1, 6));
                    default: max_len = 4'($urandom_range(15));
                endcase
                min_len = 4'($urandom_range(7));
            end
            if ($urandom_range(400) == 0) begin
                do_reset(1'($urandom_range(1)));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
